// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: receive-side checker for the divided lock clock.
// Brings slow_clk_in into the Clk_100M domain, measures its period and high
// phase, declares lock after LOCK_COUNT consecutive good periods, and raises
// a sticky fault on an out-of-tolerance period or a stalled input.
module slow_clk_monitor #(
  parameter int CNT_W      = 27,
  parameter int NOMINAL    = 250000,
  parameter int TOL        = 1250,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 500000
) (
  input  logic             Clk_100M,
  input  logic             rst,
  input  logic             slow_clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             fault,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACQ    = 2'b01,
    LOCKED = 2'b10,
    LOST   = 2'b11
  } state_t;

  localparam int GCNT_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  LO_C      = CNT_W'(NOMINAL - TOL);
  localparam logic [CNT_W-1:0]  HI_C      = CNT_W'(NOMINAL + TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [GCNT_W-1:0] LOCK_C    = GCNT_W'(LOCK_COUNT);

  // The saturated period counter must sit above any good period and leave
  // headroom for the +1 measurement without wrapping.
  if (!((NOMINAL + TOL < TIMEOUT) && (TIMEOUT < (2 ** CNT_W) - 1))) begin : g_param_check
    $error("slow_clk_monitor: need NOMINAL+TOL < TIMEOUT < 2**CNT_W-1");
  end

  state_t             st;
  logic               s1, s2, s3;
  logic               rise, fall;
  logic [CNT_W-1:0]   pcnt, hcnt;
  logic [CNT_W-1:0]   p_meas;
  logic               good;
  logic               timed_out;
  logic [GCNT_W-1:0]  gcnt;
  logic [GCNT_W-1:0]  gcnt_inc;

  // Two-flop synchroniser plus one delay stage for edge detection.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the chain.
  always_ff @(posedge Clk_100M or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slow_clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;
  assign p_meas    = pcnt + CNT_W'(1);
  assign good      = (p_meas >= LO_C) && (p_meas <= HI_C);
  assign timed_out = (pcnt == TIMEOUT_C);
  assign gcnt_inc  = gcnt + GCNT_W'(1);
  assign state     = st;

  // Period counter: restarts on each rise, saturates at TIMEOUT when stalled.
  always_ff @(posedge Clk_100M or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (rise) begin
      pcnt <= '0;
    end else if (!timed_out) begin
      pcnt <= p_meas;
    end
  end

  // High-phase counter: restarts on rise, counts synchronised-high cycles.
  always_ff @(posedge Clk_100M or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
    end else if (rise) begin
      hcnt <= '0;
    end else if (s2 && (hcnt != TIMEOUT_C)) begin
      hcnt <= hcnt + CNT_W'(1);
    end
  end

  // Capture the high time on each fall once the monitor has armed.
  always_ff @(posedge Clk_100M or posedge rst) begin
    if (rst) begin
      high_time <= '0;
    end else if (fall && (st != IDLE)) begin
      high_time <= hcnt + CNT_W'(1);
    end
  end

  // Lock FSM with registered period, strobe, locked and sticky fault outputs.
  always_ff @(posedge Clk_100M or posedge rst) begin
    if (rst) begin
      st           <= IDLE;
      gcnt         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      case (st)
        IDLE: begin
          gcnt <= '0;
          if (rise) st <= ACQ;
        end
        ACQ: begin
          if (rise) begin
            period       <= p_meas;
            period_valid <= 1'b1;
            if (!good) begin
              gcnt <= '0;
            end else if (gcnt_inc == LOCK_C) begin
              gcnt   <= '0;
              st     <= LOCKED;
              locked <= 1'b1;
            end else begin
              gcnt <= gcnt_inc;
            end
          end else if (timed_out) begin
            gcnt  <= '0;
            st    <= LOST;
            fault <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise) begin
            period       <= p_meas;
            period_valid <= 1'b1;
            if (!good) begin
              st     <= LOST;
              locked <= 1'b0;
              fault  <= 1'b1;
            end
          end else if (timed_out) begin
            st     <= LOST;
            locked <= 1'b0;
            fault  <= 1'b1;
          end
        end
        LOST: begin
          // The rise out of LOST only re-arms acquisition.
          if (rise) begin
            gcnt <= '0;
            st   <= ACQ;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule
